// File: rtl/tlb_req_arbiter_pkg.sv
// Shared types and constants for the TLB request arbiter.
// Optional feature macro used by the arbiter: TLB_ARB_RR_EN (round-robin arbitration).
package tlb_req_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  localparam logic [1:0] PRV_U = 2'd0;
  localparam logic [1:0] PRV_S = 2'd1;
  localparam logic [1:0] PRV_M = 2'd3;

  localparam int DEF_VPN_W = 27;
  localparam int DEF_PPN_W = 20;

endpackage

// File: rtl/tlb_req_arbiter_if.sv
// Downstream TLB request/response channel bundle.
// Handshake: a request transfers on a cycle where req_valid and req_ready are both 1;
// once raised, req_valid and its payload hold until that cycle. resp_valid is a one-cycle strobe.
interface tlb_req_arbiter_if #(
  parameter int VPN_W = 27,
  parameter int PPN_W = 20
);
  logic             req_valid;
  logic             req_ready;
  logic [VPN_W-1:0] req_vpn;
  logic             req_instruction;
  logic             req_priv_s;
  logic             req_vm_enabled;
  logic             resp_valid;
  logic             resp_miss;
  logic [PPN_W-1:0] resp_ppn;

  modport master (
    output req_valid, req_vpn, req_instruction, req_priv_s, req_vm_enabled,
    input  req_ready, resp_valid, resp_miss, resp_ppn
  );

  modport slave (
    input  req_valid, req_vpn, req_instruction, req_priv_s, req_vm_enabled,
    output req_ready, resp_valid, resp_miss, resp_ppn
  );
endinterface

// File: rtl/tlb_req_arbiter_priv_decode.sv
// Effective-privilege and translation-enable decode for the request being accepted.
module tlb_priv_decode
  import tlb_req_arbiter_pkg::*;
(
  input  logic       mprv,
  input  logic [1:0] mpp,
  input  logic [1:0] prv,
  input  logic       debug,
  input  logic       vm_3,
  input  logic       instruction,
  input  logic       passthrough,
  output logic       priv_s,
  output logic       vm_enabled
);
  logic       do_mprv;
  logic [1:0] priv;

  // Fetches always use the current privilege; only data accesses honour mprv.
  assign do_mprv    = mprv & ~instruction;
  assign priv       = do_mprv ? mpp : prv;
  assign priv_s     = (priv == PRV_S);
  assign vm_enabled = vm_3 & (priv <= PRV_S) & ~debug & ~passthrough;
endmodule

// File: rtl/tlb_req_arbiter.sv
// Two-port (instruction/data) arbiter in front of a single-outstanding TLB.
// Define TLB_ARB_RR_EN for round-robin arbitration; otherwise data port has fixed priority.
module tlb_req_arbiter
  import tlb_req_arbiter_pkg::*;
#(
  parameter int VPN_W = DEF_VPN_W,
  parameter int PPN_W = DEF_PPN_W
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             io_i_req_valid,
  output logic             io_i_req_ready,
  input  logic [VPN_W-1:0] io_i_req_vpn,
  input  logic             io_i_req_passthrough,
  input  logic             io_d_req_valid,
  output logic             io_d_req_ready,
  input  logic [VPN_W-1:0] io_d_req_vpn,
  input  logic             io_d_req_passthrough,
  input  logic             io_ptw_status_mprv,
  input  logic [1:0]       io_ptw_status_mpp,
  input  logic [1:0]       io_ptw_status_prv,
  input  logic             io_ptw_status_debug,
  input  logic             io_ptw_status_vm_3,
  output logic             io_tlb_req_valid,
  input  logic             io_tlb_req_ready,
  output logic [VPN_W-1:0] io_tlb_req_vpn,
  output logic             io_tlb_req_instruction,
  output logic             io_tlb_req_priv_s,
  output logic             io_tlb_req_vm_enabled,
  input  logic             io_tlb_resp_valid,
  input  logic             io_tlb_resp_miss,
  input  logic [PPN_W-1:0] io_tlb_resp_ppn,
  output logic             io_i_resp_valid,
  output logic             io_i_resp_miss,
  output logic [PPN_W-1:0] io_i_resp_ppn,
  output logic             io_d_resp_valid,
  output logic             io_d_resp_miss,
  output logic [PPN_W-1:0] io_d_resp_ppn
);
  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_ISSUE = ST_ISSUE;
  localparam logic [1:0] S_WAIT  = ST_WAIT;

  logic [1:0]       state_q, state_d;
  logic             owner_i_q, owner_i_d;
  logic [VPN_W-1:0] vpn_q, vpn_d;
  logic             priv_s_q, priv_s_d;
  logic             vm_en_q, vm_en_d;
  logic             i_resp_valid_q, i_resp_valid_d;
  logic             i_resp_miss_q, i_resp_miss_d;
  logic [PPN_W-1:0] i_resp_ppn_q, i_resp_ppn_d;
  logic             d_resp_valid_q, d_resp_valid_d;
  logic             d_resp_miss_q, d_resp_miss_d;
  logic [PPN_W-1:0] d_resp_ppn_q, d_resp_ppn_d;

  logic             is_idle, prefer_i, grant_i, grant_d, accept;
  logic             win_pass, dec_priv_s, dec_vm_en;
  logic [VPN_W-1:0] win_vpn;

`ifdef TLB_ARB_RR_EN
  // Set when the data port won the last accept, so the instruction port goes next on a tie.
  logic last_d_q, last_d_d;

  always_comb begin
    last_d_d = last_d_q;
    if (accept) last_d_d = grant_d;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) last_d_q <= 1'b0;
    else          last_d_q <= last_d_d;
  end

  assign prefer_i = last_d_q;
`else
  assign prefer_i = 1'b0;
`endif

  assign is_idle  = (state_q == S_IDLE);
  assign grant_i  = is_idle & io_i_req_valid & (~io_d_req_valid | prefer_i);
  assign grant_d  = is_idle & io_d_req_valid & (~io_i_req_valid | ~prefer_i);
  assign accept   = grant_i | grant_d;
  assign win_vpn  = grant_i ? io_i_req_vpn : io_d_req_vpn;
  assign win_pass = grant_i ? io_i_req_passthrough : io_d_req_passthrough;

  tlb_priv_decode u_priv_decode (
    .mprv        (io_ptw_status_mprv),
    .mpp         (io_ptw_status_mpp),
    .prv         (io_ptw_status_prv),
    .debug       (io_ptw_status_debug),
    .vm_3        (io_ptw_status_vm_3),
    .instruction (grant_i),
    .passthrough (win_pass),
    .priv_s      (dec_priv_s),
    .vm_enabled  (dec_vm_en)
  );

  always_comb begin
    state_d        = state_q;
    owner_i_d      = owner_i_q;
    vpn_d          = vpn_q;
    priv_s_d       = priv_s_q;
    vm_en_d        = vm_en_q;
    i_resp_valid_d = 1'b0;
    i_resp_miss_d  = i_resp_miss_q;
    i_resp_ppn_d   = i_resp_ppn_q;
    d_resp_valid_d = 1'b0;
    d_resp_miss_d  = d_resp_miss_q;
    d_resp_ppn_d   = d_resp_ppn_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d   = S_ISSUE;
          owner_i_d = grant_i;
          vpn_d     = win_vpn;
          priv_s_d  = dec_priv_s;
          vm_en_d   = dec_vm_en;
        end
      end
      S_ISSUE: begin
        if (io_tlb_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (io_tlb_resp_valid) begin
          state_d = S_IDLE;
          if (owner_i_q) begin
            i_resp_valid_d = 1'b1;
            i_resp_miss_d  = io_tlb_resp_miss;
            i_resp_ppn_d   = io_tlb_resp_ppn;
          end else begin
            d_resp_valid_d = 1'b1;
            d_resp_miss_d  = io_tlb_resp_miss;
            d_resp_ppn_d   = io_tlb_resp_ppn;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      owner_i_q      <= 1'b0;
      vpn_q          <= '0;
      priv_s_q       <= 1'b0;
      vm_en_q        <= 1'b0;
      i_resp_valid_q <= 1'b0;
      i_resp_miss_q  <= 1'b0;
      i_resp_ppn_q   <= '0;
      d_resp_valid_q <= 1'b0;
      d_resp_miss_q  <= 1'b0;
      d_resp_ppn_q   <= '0;
    end else begin
      state_q        <= state_d;
      owner_i_q      <= owner_i_d;
      vpn_q          <= vpn_d;
      priv_s_q       <= priv_s_d;
      vm_en_q        <= vm_en_d;
      i_resp_valid_q <= i_resp_valid_d;
      i_resp_miss_q  <= i_resp_miss_d;
      i_resp_ppn_q   <= i_resp_ppn_d;
      d_resp_valid_q <= d_resp_valid_d;
      d_resp_miss_q  <= d_resp_miss_d;
      d_resp_ppn_q   <= d_resp_ppn_d;
    end
  end

  // Readies are combinational, so gate them with reset to keep them low while it is held.
  assign io_i_req_ready         = grant_i & reset_n;
  assign io_d_req_ready         = grant_d & reset_n;
  assign io_tlb_req_valid       = (state_q == S_ISSUE);
  assign io_tlb_req_vpn         = vpn_q;
  assign io_tlb_req_instruction = owner_i_q;
  assign io_tlb_req_priv_s      = priv_s_q;
  assign io_tlb_req_vm_enabled  = vm_en_q;
  assign io_i_resp_valid        = i_resp_valid_q;
  assign io_i_resp_miss         = i_resp_miss_q;
  assign io_i_resp_ppn          = i_resp_ppn_q;
  assign io_d_resp_valid        = d_resp_valid_q;
  assign io_d_resp_miss         = d_resp_miss_q;
  assign io_d_resp_ppn          = d_resp_ppn_q;
endmodule

// File: tb/tb_tlb_req_arbiter.sv
// Directed self-checking bench for tlb_req_arbiter (fixed or TLB_ARB_RR_EN build).
module tb_tlb_req_arbiter;
  import tlb_req_arbiter_pkg::*;

  localparam int VPN_W = DEF_VPN_W;
  localparam int PPN_W = DEF_PPN_W;

  // clock / reset
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  logic             i_req_valid, i_req_ready, i_req_pass;
  logic [VPN_W-1:0] i_req_vpn;
  logic             d_req_valid, d_req_ready, d_req_pass;
  logic [VPN_W-1:0] d_req_vpn;
  logic             st_mprv, st_debug, st_vm_3;
  logic [1:0]       st_mpp, st_prv;
  logic             i_resp_valid, i_resp_miss, d_resp_valid, d_resp_miss;
  logic [PPN_W-1:0] i_resp_ppn, d_resp_ppn;

  tlb_req_arbiter_if #(.VPN_W(VPN_W), .PPN_W(PPN_W)) tlb_if ();

  tlb_req_arbiter #(.VPN_W(VPN_W), .PPN_W(PPN_W)) dut (
    .clock                  (clock),
    .reset_n                (reset_n),
    .io_i_req_valid         (i_req_valid),
    .io_i_req_ready         (i_req_ready),
    .io_i_req_vpn           (i_req_vpn),
    .io_i_req_passthrough   (i_req_pass),
    .io_d_req_valid         (d_req_valid),
    .io_d_req_ready         (d_req_ready),
    .io_d_req_vpn           (d_req_vpn),
    .io_d_req_passthrough   (d_req_pass),
    .io_ptw_status_mprv     (st_mprv),
    .io_ptw_status_mpp      (st_mpp),
    .io_ptw_status_prv      (st_prv),
    .io_ptw_status_debug    (st_debug),
    .io_ptw_status_vm_3     (st_vm_3),
    .io_tlb_req_valid       (tlb_if.req_valid),
    .io_tlb_req_ready       (tlb_if.req_ready),
    .io_tlb_req_vpn         (tlb_if.req_vpn),
    .io_tlb_req_instruction (tlb_if.req_instruction),
    .io_tlb_req_priv_s      (tlb_if.req_priv_s),
    .io_tlb_req_vm_enabled  (tlb_if.req_vm_enabled),
    .io_tlb_resp_valid      (tlb_if.resp_valid),
    .io_tlb_resp_miss       (tlb_if.resp_miss),
    .io_tlb_resp_ppn        (tlb_if.resp_ppn),
    .io_i_resp_valid        (i_resp_valid),
    .io_i_resp_miss         (i_resp_miss),
    .io_i_resp_ppn          (i_resp_ppn),
    .io_d_resp_valid        (d_resp_valid),
    .io_d_resp_miss         (d_resp_miss),
    .io_d_resp_ppn          (d_resp_ppn)
  );

  int n_cmp = 0;
  int n_err = 0;
  int i_cnt = 0;
  int d_cnt = 0;
  int i_snap, d_snap;

  // Count response pulses mid-cycle, away from the active edge.
  always @(negedge clock) begin
    if (i_resp_valid === 1'b1) i_cnt++;
    if (d_resp_valid === 1'b1) d_cnt++;
  end

  // driver tasks
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    step();
    reset_n = 1'b1;
    step();
  endtask

  // One full transaction with tlb_ready high; ends in the cycle the response is visible.
  task automatic txn(input logic use_i, input logic use_d,
                     input logic [VPN_W-1:0] vpn_i, input logic [VPN_W-1:0] vpn_d,
                     input logic exp_i_win, input logic [PPN_W-1:0] ppn, input logic miss,
                     input logic exp_ps, input logic exp_vm);
    i_req_valid = use_i;
    i_req_vpn   = vpn_i;
    d_req_valid = use_d;
    d_req_vpn   = vpn_d;
    tlb_if.req_ready = 1'b1;
    #1;
    chk("i_req_ready", 32'(i_req_ready), 32'(exp_i_win));
    chk("d_req_ready", 32'(d_req_ready), 32'(!exp_i_win));
    step();
    i_req_valid = 1'b0;
    d_req_valid = 1'b0;
    #1;
    chk("tlb_req_valid", 32'(tlb_if.req_valid), 32'd1);
    chk("tlb_req_vpn", 32'(tlb_if.req_vpn), 32'(exp_i_win ? vpn_i : vpn_d));
    chk("tlb_req_instruction", 32'(tlb_if.req_instruction), 32'(exp_i_win));
    chk("tlb_req_priv_s", 32'(tlb_if.req_priv_s), 32'(exp_ps));
    chk("tlb_req_vm_enabled", 32'(tlb_if.req_vm_enabled), 32'(exp_vm));
    step();
    tlb_if.resp_valid = 1'b1;
    tlb_if.resp_ppn   = ppn;
    tlb_if.resp_miss  = miss;
    #1;
    chk("tlb_req_valid_wait", 32'(tlb_if.req_valid), 32'd0);
    step();
    tlb_if.resp_valid = 1'b0;
    #1;
    chk("i_resp_valid", 32'(i_resp_valid), 32'(exp_i_win));
    chk("d_resp_valid", 32'(d_resp_valid), 32'(!exp_i_win));
    chk("resp_ppn", 32'(exp_i_win ? i_resp_ppn : d_resp_ppn), 32'(ppn));
    chk("resp_miss", 32'(exp_i_win ? i_resp_miss : d_resp_miss), 32'(miss));
  endtask

  initial begin
    logic exp_i_win;
    i_req_valid = 0; i_req_vpn = '0; i_req_pass = 0;
    d_req_valid = 0; d_req_vpn = '0; d_req_pass = 0;
    st_mprv = 0; st_mpp = 2'd0; st_prv = 2'd0; st_debug = 0; st_vm_3 = 0;
    tlb_if.req_ready = 0; tlb_if.resp_valid = 0; tlb_if.resp_miss = 0; tlb_if.resp_ppn = '0;

    // reset state
    repeat (2) @(posedge clock);
    #1;
    chk("rst_tlb_req_valid", 32'(tlb_if.req_valid), 32'd0);
    chk("rst_tlb_req_vpn", 32'(tlb_if.req_vpn), 32'd0);
    chk("rst_i_resp_valid", 32'(i_resp_valid), 32'd0);
    chk("rst_d_resp_valid", 32'(d_resp_valid), 32'd0);
    reset_n = 1'b1;
    step();

    // single data request, supervisor with paging
    st_prv = 2'd1; st_vm_3 = 1'b1;
    txn(1'b0, 1'b1, '0, 27'h1234, 1'b0, 20'h55, 1'b0, 1'b1, 1'b1);
    step();
    chk("single_d_pulses", 32'(d_cnt), 32'd1);
    chk("single_i_pulses", 32'(i_cnt), 32'd0);

    // mprv ignored for fetches, honoured for data; back-to-back accept on the response cycle
    st_mprv = 1'b1; st_mpp = 2'd1; st_prv = 2'd3;
    txn(1'b1, 1'b0, 27'h300, '0, 1'b1, 20'h77, 1'b1, 1'b0, 1'b0);
    txn(1'b0, 1'b1, '0, 27'h301, 1'b0, 20'h78, 1'b0, 1'b1, 1'b1);

    // passthrough suppresses translation; user mode translates but is not supervisor
    st_mprv = 1'b0; st_prv = 2'd1; d_req_pass = 1'b1;
    txn(1'b0, 1'b1, '0, 27'h302, 1'b0, 20'h79, 1'b0, 1'b1, 1'b0);
    d_req_pass = 1'b0; st_prv = 2'd0;
    txn(1'b1, 1'b0, 27'h303, '0, 1'b1, 20'h7a, 1'b0, 1'b0, 1'b1);

    // simultaneous requests, three rounds from a fresh reset
    st_prv = 2'd1;
    do_reset();
    for (int r = 0; r < 3; r++) begin
`ifdef TLB_ARB_RR_EN
      exp_i_win = (r == 1);
`else
      exp_i_win = 1'b0;
`endif
      txn(1'b1, 1'b1, 27'(32'h100 + r), 27'(32'h200 + r), exp_i_win,
          20'(32'h10 + r), 1'b0, 1'b1, 1'b1);
    end

    // backpressure: payload stable, late status change and stray response ignored
    step();
    d_snap = d_cnt; i_snap = i_cnt;
    tlb_if.req_ready = 1'b0;
    d_req_valid = 1'b1; d_req_vpn = 27'h4444;
    #1;
    chk("bp_d_req_ready", 32'(d_req_ready), 32'd1);
    step();
    d_req_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_tlb_req_valid", 32'(tlb_if.req_valid), 32'd1);
      chk("bp_tlb_req_vpn", 32'(tlb_if.req_vpn), 32'h4444);
      chk("bp_tlb_req_priv_s", 32'(tlb_if.req_priv_s), 32'd1);
      if (k == 1) st_prv = 2'd3;
      tlb_if.resp_valid = (k == 2);
      step();
    end
    tlb_if.req_ready = 1'b1;
    #1;
    chk("bp_release_valid", 32'(tlb_if.req_valid), 32'd1);
    step();
    tlb_if.resp_valid = 1'b1; tlb_if.resp_ppn = 20'h44; tlb_if.resp_miss = 1'b0;
    step();
    tlb_if.resp_valid = 1'b0;
    #1;
    chk("bp_d_resp_valid", 32'(d_resp_valid), 32'd1);
    chk("bp_d_resp_ppn", 32'(d_resp_ppn), 32'h44);
    step();
    chk("bp_d_pulses", 32'(d_cnt), 32'(d_snap + 1));
    chk("bp_i_pulses", 32'(i_cnt), 32'(i_snap));

    // reset while waiting for the TLB response
    st_prv = 2'd1;
    d_req_valid = 1'b1; d_req_vpn = 27'h5555;
    step();
    d_req_valid = 1'b0;
    step();
    #1;
    chk("mid_in_wait", 32'(tlb_if.req_valid), 32'd0);
    reset_n = 1'b0;
    i_req_valid = 1'b1; d_req_valid = 1'b1;
    #1;
    chk("mid_rst_tlb_req_vpn", 32'(tlb_if.req_vpn), 32'd0);
    chk("mid_rst_priv_s", 32'(tlb_if.req_priv_s), 32'd0);
    chk("mid_rst_vm_enabled", 32'(tlb_if.req_vm_enabled), 32'd0);
    chk("mid_rst_i_ready", 32'(i_req_ready), 32'd0);
    chk("mid_rst_d_ready", 32'(d_req_ready), 32'd0);
    chk("mid_rst_d_resp_ppn", 32'(d_resp_ppn), 32'd0);
    chk("mid_rst_i_resp_miss", 32'(i_resp_miss), 32'd0);
    d_snap = d_cnt; i_snap = i_cnt;
    step();
    i_req_valid = 1'b0; d_req_valid = 1'b0;
    reset_n = 1'b1;
    step();
    tlb_if.resp_valid = 1'b1; tlb_if.resp_ppn = 20'h66;
    step();
    tlb_if.resp_valid = 1'b0;
    step();
    chk("post_rst_d_pulses", 32'(d_cnt), 32'(d_snap));
    chk("post_rst_i_pulses", 32'(i_cnt), 32'(i_snap));

    // stray response in IDLE
    tlb_if.resp_valid = 1'b1; tlb_if.resp_ppn = 20'h99;
    step();
    tlb_if.resp_valid = 1'b0;
    #1;
    chk("stray_i_resp_valid", 32'(i_resp_valid), 32'd0);
    chk("stray_d_resp_valid", 32'(d_resp_valid), 32'd0);
    chk("stray_tlb_req_valid", 32'(tlb_if.req_valid), 32'd0);
    step();
    chk("stray_d_pulses", 32'(d_cnt), 32'(d_snap));

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/tlb_req_arbiter.md
TLB_REQ_ARBITER -- requirements
Module: tlb_req_arbiter

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- VPN_W, 27, virtual page number width.
- PPN_W, 20, physical page number width.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clock, in, 1, sole clock.
- reset_n, in, 1, asynchronous active-low reset.
- io_i_req_valid / io_i_req_ready, in / out, 1, instruction-port request handshake.
- io_i_req_vpn, in, VPN_W, instruction-port virtual page number.
- io_i_req_passthrough, in, 1, instruction-port bypass translation.
- io_d_req_valid / io_d_req_ready / io_d_req_vpn / io_d_req_passthrough: same as the instruction port, for the data port.
- io_ptw_status_mprv, in, 1, modify-privilege enable.
- io_ptw_status_mpp, in, 2, previous privilege.
- io_ptw_status_prv, in, 2, current privilege.
- io_ptw_status_debug, in, 1, debug mode.
- io_ptw_status_vm_3, in, 1, paging mode enabled.
- io_tlb_req_valid / io_tlb_req_ready, out / in, 1, downstream TLB request handshake.
- io_tlb_req_vpn, out, VPN_W, latched VPN.
- io_tlb_req_instruction, out, 1, 1 = instruction-port owner.
- io_tlb_req_priv_s, out, 1, effective privilege is supervisor.
- io_tlb_req_vm_enabled, out, 1, translation required.
- io_tlb_resp_valid, in, 1, TLB response strobe.
- io_tlb_resp_miss, in, 1, TLB miss.
- io_tlb_resp_ppn, in, PPN_W, TLB physical page number.
- io_i_resp_valid / io_i_resp_miss / io_i_resp_ppn, out, 1/1/PPN_W, instruction-port response.
- io_d_resp_valid / io_d_resp_miss / io_d_resp_ppn, out, 1/1/PPN_W, data-port response.

Function
REQ-003 The FSM SHALL have states IDLE, ISSUE and WAIT; there SHALL be one outstanding request at most.
REQ-004 IDLE behaviour:
- When any req_valid is high, assert the winner's req_ready combinationally that cycle, latch its vpn, passthrough and owner, and go to ISSUE.
- The loser's ready SHALL be 0.
REQ-005 At the accept cycle, the block SHALL snapshot the effective privilege, computed as follows:
- do_mprv = mprv & ~instruction.
- priv = do_mprv ? mpp : prv.
- priv_s = (priv == 1).
- vm_enabled = vm_3 & (priv <= 1) & ~debug & ~passthrough.
- Later status changes SHALL NOT alter an accepted request.
REQ-006 ISSUE behaviour:
- io_tlb_req_valid = 1, with vpn, instruction, priv_s and vm_enabled held stable.
- On io_tlb_req_ready = 1, go to WAIT.
- valid SHALL NOT drop before ready.
REQ-007 WAIT behaviour: on io_tlb_resp_valid, register miss and ppn into the owner's resp outputs, pulse the owner's resp_valid for exactly one cycle (the next cycle), and return to IDLE.
REQ-008 The non-owner resp_valid SHALL stay 0.
REQ-009 An io_tlb_resp_valid arriving in IDLE or ISSUE SHALL be ignored.
REQ-010 Minimum latency SHALL be: accept at cycle N, tlb_req_valid at N+1, resp_valid at (TLB resp cycle)+1.
REQ-011 A new accept SHALL be possible in the same cycle as the owner resp_valid pulse (IDLE re-entered).
REQ-012 Default priority SHALL be fixed, with the data port winning on simultaneous valid.

Reset
REQ-013 Assertion of reset_n low SHALL immediately and asynchronously:
- force IDLE;
- drive all valid, ready and resp outputs and the latched fields to 0;
- clear the round-robin pointer to 0 (data preferred).
REQ-014 A request in flight at reset SHALL be dropped with no response.

Configuration
REQ-015 With TLB_ARB_RR_EN defined, arbitration SHALL be round-robin:
- a 1-bit pointer records the last granted port;
- on simultaneous valid, the other port wins;
- the pointer updates only on accept.
REQ-016 Without TLB_ARB_RR_EN, the pointer SHALL be absent and fixed data-first priority SHALL apply.

Structure
REQ-017 A shared package SHALL hold the following:
- the FSM state enum (IDLE = 0, ISSUE = 1, WAIT = 2);
- the privilege constants (PRV_U = 0, PRV_S = 1, PRV_M = 3);
- default VPN_W and PPN_W.
REQ-018 The privilege/vm-enable computation of REQ-005 SHALL be a combinational sub-module named tlb_priv_decode, instantiated once.

Verification
REQ-019 Single data request: d_valid with vpn=0x1234, prv=1, vm_3=1, tlb_ready=1, resp ppn=0x55 -> the bench SHALL see:
- d_ready=1 at N;
- tlb_req_valid=1 at N+1 with priv_s=1 and vm_enabled=1;
- d_resp_valid=1 with ppn=0x55 exactly once;
- i_resp_valid=0 throughout.
REQ-020 Simultaneous i_valid and d_valid in three consecutive rounds -> the bench SHALL see:
- fixed mode: the data port wins every time;
- TLB_ARB_RR_EN mode: winners d, i, d.
REQ-021 Instruction request with mprv=1, mpp=1, prv=3 -> priv_s=0 and vm_enabled=0 (mprv ignored for instruction); the same via the data port -> priv_s=1 and vm_enabled=1.
REQ-022 Backpressure: tlb_ready held low 5 cycles -> tlb_req_valid and vpn SHALL stay stable for 5 cycles; a status change during that window SHALL NOT change priv_s.
REQ-023 Reset mid-operation: reset_n low in WAIT -> all outputs 0 immediately; after release, no resp_valid even if tlb_resp_valid pulses.
REQ-024 Stray response: tlb_resp_valid in IDLE -> no resp_valid on either port.
